// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-requester (fetch / data) arbiter for one shared memory
//                port. Data side wins contention for up to MAX_D_STREAK
//                consecutive grants, after which fetch is served.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_D_STREAK = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  if_req_i,
    input  logic [ADDR_WIDTH-1:0] if_addr_i,
    output logic [DATA_WIDTH-1:0] if_rdata_o,
    output logic                  if_ack_o,
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_WIDTH-1:0] d_addr_i,
    input  logic [DATA_WIDTH-1:0] d_wdata_i,
    output logic [DATA_WIDTH-1:0] d_rdata_o,
    output logic                  d_ack_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ready_i,
    output logic                  stall_f_o,
    output logic                  stall_m_o
);

    localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [STREAK_W-1:0]   streak_q,   streak_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic                  we_q,       we_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  fetch_q,    fetch_d;    // owner of the current/last transaction
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q,  d_rdata_d;

    // Next-state logic: arbitration in IDLE, completion in BUSY, single-cycle DONE
    always_comb begin
        state_d    = state_q;
        streak_d   = streak_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        fetch_d    = fetch_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                // Data wins unless it has already taken MAX_D_STREAK grants in a
                // row against a waiting fetch; the streak only counts contended wins.
                if (d_req_i && (!if_req_i || (streak_q < STREAK_MAX))) begin
                    state_d = BUSY_D;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    wdata_d = d_wdata_i;
                    fetch_d = 1'b0;
                    if (if_req_i) begin
                        streak_d = streak_q + 1'b1;
                    end
                end else if (if_req_i) begin
                    state_d  = BUSY_I;
                    addr_d   = if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    fetch_d  = 1'b1;
                    streak_d = '0;
                end
            end
            BUSY_I: begin
                if (mem_ready_i) begin
                    if_rdata_d = mem_rdata_i;
                    state_d    = DONE;
                end
            end
            BUSY_D: begin
                if (mem_ready_i) begin
                    if (!we_q) begin
                        d_rdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            fetch_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            fetch_q    <= fetch_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign mem_req_o   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;

    // Acks are decoded from DONE so they can never overlap or appear elsewhere
    assign if_ack_o    = (state_q == DONE) && fetch_q;
    assign d_ack_o     = (state_q == DONE) && !fetch_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

    assign stall_f_o   = if_req_i & ~if_ack_o;
    assign stall_m_o   = d_req_i & ~d_ack_o;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter: directed scenarios plus
//                randomized traffic against a timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int MAXS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we, mem_ready;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
    logic [AW-1:0] mem_addr_o;
    logic          if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_f_o, stall_m_o;

    always #5 clk = ~clk;

    mem_arbiter #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .MAX_D_STREAK (MAXS)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .if_req_i    (if_req),
        .if_addr_i   (if_addr),
        .if_rdata_o  (if_rdata_o),
        .if_ack_o    (if_ack_o),
        .d_req_i     (d_req),
        .d_we_i      (d_we),
        .d_addr_i    (d_addr),
        .d_wdata_i   (d_wdata),
        .d_rdata_o   (d_rdata_o),
        .d_ack_o     (d_ack_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .stall_f_o   (stall_f_o),
        .stall_m_o   (stall_m_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: transactions described by cycle timestamps.
    // cyc is the index of the current cycle; a grant may only be taken in a
    // cycle >= free_at; an ack appears in cycle ack_cyc for side ack_side.
    int            cyc      = 0;
    int            free_at  = 0;
    bit            act      = 1'b0;   // a granted transaction awaits its ready
    int            side     = 0;      // 0 = fetch, 1 = data
    int            ack_cyc  = -10;
    int            ack_side = 0;
    int            streak   = 0;
    logic [AW-1:0] m_addr   = '0;
    logic          m_we     = 1'b0;
    logic [DW-1:0] m_wdata  = '0;
    logic [DW-1:0] m_if_rd  = '0;
    logic [DW-1:0] m_d_rd   = '0;

    // Apply the inputs seen at the clock edge that ends cycle cyc
    task automatic model_edge();
        if (rst) begin
            act = 1'b0; streak = 0; free_at = cyc + 1; ack_cyc = -10;
            m_if_rd = '0; m_d_rd = '0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
        end else if (act) begin
            if (mem_ready) begin
                act      = 1'b0;
                ack_cyc  = cyc + 1;
                ack_side = side;
                free_at  = cyc + 2;
                if (side == 0) m_if_rd = mem_rdata;
                else if (!m_we) m_d_rd = mem_rdata;
            end
        end else if (cyc >= free_at && (if_req || d_req)) begin
            if (d_req && (!if_req || streak < MAXS)) begin
                side = 1; m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
                if (if_req) streak = streak + 1;
            end else begin
                side = 0; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
                streak = 0;
            end
            act = 1'b1;
        end
        cyc++;
    endtask

    // One clock cycle: stall check before the edge, model update, output check after
    task automatic tick();
        #1;
        check("stall_f", stall_f_o, if_req & ~(cyc == ack_cyc && ack_side == 0));
        check("stall_m", stall_m_o, d_req  & ~(cyc == ack_cyc && ack_side == 1));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mem_req",  mem_req_o,  act);
        check("if_ack",   if_ack_o,   cyc == ack_cyc && ack_side == 0);
        check("d_ack",    d_ack_o,    cyc == ack_cyc && ack_side == 1);
        check("if_rdata", if_rdata_o, m_if_rd);
        check("d_rdata",  d_rdata_o,  m_d_rd);
        check("ack_excl", if_ack_o & d_ack_o, 1'b0);
        if (act) begin
            check("mem_addr", mem_addr_o, m_addr);
            check("mem_we",   mem_we_o,   m_we);
            if (side == 1) check("mem_wdata", mem_wdata_o, m_wdata);
        end
    endtask

    int  ack_log[$];
    bit  rst_was;

    initial begin
        rst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_mem_req", mem_req_o, 1'b0);
        check("rst_rdata",   {if_rdata_o, d_rdata_o}, 64'h0);
        rst = 1'b0;

        // Fetch read with ready in the first BUSY cycle
        if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'h0050_0093;
        tick();
        check("t1_mem_req",  mem_req_o,  1'b1);
        check("t1_mem_addr", mem_addr_o, 32'h10);
        tick();
        check("t1_if_ack",   if_ack_o,   1'b1);
        check("t1_if_rdata", if_rdata_o, 32'h0050_0093);
        if_req = 0; mem_ready = 0;
        tick();
        check("t1_ack_pulse", if_ack_o, 1'b0);

        // Data read, then a write that must leave d_rdata untouched
        d_req = 1; d_we = 0; d_addr = 32'h44; mem_ready = 1; mem_rdata = 32'hCAFE_F00D;
        tick(); tick();
        check("t2_d_rdata", d_rdata_o, 32'hCAFE_F00D);
        d_req = 0; mem_ready = 0;
        tick();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; mem_rdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_we_held", mem_we_o, 1'b1);
            check("t2_no_ack",  d_ack_o,  1'b0);
        end
        mem_ready = 1;
        tick();
        check("t2_d_ack",       d_ack_o,   1'b1);
        check("t2_rdata_keep",  d_rdata_o, 32'hCAFE_F00D);
        d_req = 0; d_we = 0; mem_ready = 0;
        tick();

        // Contention with one-cycle memory: expect D,D,D,I repeating
        if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h300; mem_ready = 1;
        for (int i = 0; i < 32; i++) begin
            mem_rdata = $urandom;
            tick();
            if (if_ack_o) ack_log.push_back(0);
            if (d_ack_o)  ack_log.push_back(1);
        end
        check("t3_grant_count", ack_log.size() >= 8, 1'b1);
        for (int k = 0; k < 8 && k < ack_log.size(); k++)
            check($sformatf("t3_order[%0d]", k), ack_log[k], (k % 4 == 3) ? 0 : 1);
        if_req = 0; d_req = 0; mem_ready = 0;
        tick(); tick(); tick();

        // Reset in the middle of a data transaction
        rst = 1; tick(); rst = 0;
        d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 0;
        tick();
        check("t4_busy", mem_req_o, 1'b1);
        rst = 1; d_req = 0;
        tick();
        rst = 0; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_ack",  d_ack_o,   1'b0);
            check("t4_no_req",  mem_req_o, 1'b0);
            check("t4_d_rdata", d_rdata_o, 32'h0);
        end

        // Idle with toggling ready, then a fetch starved of ready
        for (int i = 0; i < 6; i++) begin
            mem_ready = i[0];
            tick();
            check("t5_idle_req", mem_req_o, 1'b0);
            check("t5_idle_ack", if_ack_o | d_ack_o, 1'b0);
        end
        if_req = 1; if_addr = 32'h200; mem_ready = 0;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t5_req_held", mem_req_o, 1'b1);
            check("t5_stall",    stall_f_o, 1'b1);
            check("t5_no_ack",   if_ack_o,  1'b0);
        end
        mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        check("t5_ack", if_ack_o, 1'b1);
        if_req = 0; mem_ready = 0;
        tick();

        // Randomized traffic; a requester holds its request until its ack
        for (int n = 0; n < 3000; n++) begin
            rst_was = rst;
            if (!if_req || rst_was || (cyc == ack_cyc && ack_side == 0)) begin
                if_req  = ($urandom % 3) != 0;
                if_addr = $urandom;
            end
            if (!d_req || rst_was || (cyc == ack_cyc && ack_side == 1)) begin
                d_req   = ($urandom % 3) != 0;
                d_we    = $urandom % 2;
                d_addr  = $urandom;
                d_wdata = $urandom;
            end
            mem_ready = ($urandom % 3) == 0;
            mem_rdata = $urandom;
            rst       = ($urandom % 97) == 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
